// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arbiter
// Purpose : Round-robin two-port arbiter and sequencer in front of the
//           single-port data memory. Port 0 is the CPU load/store path, port 1
//           is the debug/loader path. One access at a time, each taking
//           IDLE (grant) -> ACCESS (memory strobe) -> RESP (ack) = 3 cycles.
//           Out-of-range word addresses never reach the memory strobes.
// Ports   : clk, rst           - clock, asynchronous active-high reset
//           reqN_i/weN_i/addrN_i/wdataN_i - requester N command (N = 0, 1)
//           ackN_o/errN_o/rdataN_o        - requester N completion/result
//           mem_*_o / mem_rdata_i         - data memory interface
//           busy_o             - high whenever a transaction is in flight
// Revision: 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int SIZE_DM = 128,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [31:0]       wdata0_i,
  output logic              ack0_o,
  output logic              err0_o,
  output logic [31:0]       rdata0_o,
  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [31:0]       wdata1_i,
  output logic              ack1_o,
  output logic              err1_o,
  output logic [31:0]       rdata1_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              mem_write_o,
  output logic              mem_read_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              busy_o
);

  // Full-width bound so large addresses are never aliased into range.
  localparam logic [ADDR_W-1:0] c_size_dm = ADDR_W'(SIZE_DM);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                rr_ptr_q;
  logic                port_q;
  logic                we_q;
  logic                oor_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata0_q;
  logic [31:0]         rdata1_q;

  logic                w_grant;
  logic                w_gnt_port;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [31:0]         w_sel_wdata;

  // Command of whichever port wins this IDLE cycle.
  assign w_sel_we    = w_gnt_port ? we1_i    : we0_i;
  assign w_sel_addr  = w_gnt_port ? addr1_i  : addr0_i;
  assign w_sel_wdata = w_gnt_port ? wdata1_i : wdata0_i;

  // The memory bus follows the latched command; between accesses it simply
  // keeps showing the last granted address/data.
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign rdata0_o    = rdata0_q;
  assign rdata1_o    = rdata1_q;
  assign busy_o      = (state_q != ST_IDLE);

  // State register: strobes decode from it, so reset clears them at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    w_grant     = 1'b0;
    w_gnt_port  = 1'b0;
    mem_write_o = 1'b0;
    mem_read_o  = 1'b0;
    ack0_o      = 1'b0;
    ack1_o      = 1'b0;
    err0_o      = 1'b0;
    err1_o      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req0_i || req1_i) begin
          w_grant    = 1'b1;
          // Contention goes to rr_ptr; otherwise the lone requester wins.
          w_gnt_port = (req0_i && req1_i) ? rr_ptr_q : req1_i;
          state_d    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_write_o = we_q & ~oor_q;
        mem_read_o  = ~we_q & ~oor_q;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (port_q) begin
          ack1_o = 1'b1;
          err1_o = oor_q;
        end else begin
          ack0_o = 1'b1;
          err0_o = oor_q;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Transaction latches, read-data capture and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= 1'b0;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      oor_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (w_grant) begin
        port_q  <= w_gnt_port;
        we_q    <= w_sel_we;
        addr_q  <= w_sel_addr;
        wdata_q <= w_sel_wdata;
        oor_q   <= (w_sel_addr >= c_size_dm);
      end
      if (state_q == ST_ACCESS) begin
        // Writes and blocked accesses return zero rather than bus noise.
        if (port_q) begin
          rdata1_q <= (we_q || oor_q) ? 32'h0 : mem_rdata_i;
        end else begin
          rdata0_q <= (we_q || oor_q) ? 32'h0 : mem_rdata_i;
        end
      end
      if (state_q == ST_RESP) begin
        rr_ptr_q <= ~port_q;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_arbiter
// Purpose : Self-checking bench for dmem_arbiter. Models the data memory,
//           keeps a transaction-level reference (age of the in-flight
//           transaction plus a reference memory image) and compares every
//           DUT output against it each cycle, alongside directed literal
//           expectations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int SIZE_DM = 128;
  localparam int ADDR_W  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [31:0]       wdata0 = '0, wdata1 = '0;
  logic              ack0, err0, ack1, err1;
  logic [31:0]       rdata0, rdata1;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic              mem_write, mem_read, busy;

  dmem_arbiter #(.SIZE_DM(SIZE_DM), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
    .ack0_o(ack0), .err0_o(err0), .rdata0_o(rdata0),
    .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
    .ack1_o(ack1), .err1_o(err1), .rdata1_o(rdata1),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_write_o(mem_write), .mem_read_o(mem_read),
    .mem_rdata_i(mem_rdata), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // ---------------- data memory seen by the DUT ----------------
  logic [31:0] dmem   [0:SIZE_DM-1];
  logic [31:0] refmem [0:SIZE_DM-1];

  assign mem_rdata = (mem_addr < ADDR_W'(SIZE_DM)) ? dmem[mem_addr[6:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_write && (mem_addr < ADDR_W'(SIZE_DM))) dmem[mem_addr[6:0]] <= mem_wdata;
  end

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int wr_count = 0;
  logic [31:0] last_wr_addr = '0;
  logic chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_write) begin
      wr_count++;
      last_wr_addr = mem_addr;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // m_age: 0 = no transaction, 1 = memory-access cycle, 2 = ack cycle.
  int          m_age;
  int          m_port;
  int          m_rr;
  logic        m_we, m_oor;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] exp_rd [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_age = 0; m_rr = 0; m_port = 0; m_we = 1'b0; m_oor = 1'b0;
      m_addr = '0; m_wdata = '0; exp_rd[0] = '0; exp_rd[1] = '0;
    end else if (m_age == 0) begin
      if (req0 || req1) begin
        m_port  = (req0 && req1) ? m_rr : (req1 ? 1 : 0);
        m_we    = (m_port == 1) ? we1 : we0;
        m_addr  = (m_port == 1) ? addr1 : addr0;
        m_wdata = (m_port == 1) ? wdata1 : wdata0;
        m_oor   = (m_addr >= 32'(SIZE_DM));
        m_age   = 1;
      end
    end else if (m_age == 1) begin
      if (m_oor || m_we) exp_rd[m_port] = 32'h0;
      else               exp_rd[m_port] = refmem[m_addr[6:0]];
      if (!m_oor && m_we) refmem[m_addr[6:0]] = m_wdata;
      m_age = 2;
    end else begin
      m_rr  = 1 - m_port;
      m_age = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",      32'(busy),      32'(m_age != 0));
      chk("mem_write", 32'(mem_write), 32'(m_age == 1 && m_we && !m_oor));
      chk("mem_read",  32'(mem_read),  32'(m_age == 1 && !m_we && !m_oor));
      chk("mem_addr",  mem_addr,       m_addr);
      chk("mem_wdata", mem_wdata,      m_wdata);
      chk("ack0", 32'(ack0), 32'(m_age == 2 && m_port == 0));
      chk("ack1", 32'(ack1), 32'(m_age == 2 && m_port == 1));
      chk("err0", 32'(err0), 32'(m_age == 2 && m_port == 0 && m_oor));
      chk("err1", 32'(err1), 32'(m_age == 2 && m_port == 1 && m_oor));
      chk("rdata0", rdata0, exp_rd[0]);
      chk("rdata1", rdata1, exp_rd[1]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Issue one request and hold it until ack; lat = negedges until ack seen.
  task automatic do_txn(input int port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd,
                        output logic er, output int lat);
    logic got;
    got = 1'b0; rd = '0; er = 1'b0; lat = 0;
    if (port == 1) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; end
    else           begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; end
    for (int i = 1; i <= 12 && !got; i++) begin
      @(negedge clk);
      if ((port == 1) ? ack1 : ack0) begin
        got = 1'b1;
        lat = i;
        rd  = (port == 1) ? rdata1 : rdata0;
        er  = (port == 1) ? err1 : err0;
      end
    end
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
    step();
    if (port == 1) req1 = 1'b0; else req0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, wr0;
    int          ports [4];
    int          cycs  [4];
    logic        got;

    for (int i = 0; i < SIZE_DM; i++) begin
      dmem[i]   = 32'h1000_0000 + 32'(i);
      refmem[i] = 32'h1000_0000 + 32'(i);
    end
    dmem[5]   = 32'hDEAD_BEEF;
    refmem[5] = 32'hDEAD_BEEF;

    step();
    #1;
    // Reset state before any clocked activity has been released.
    chk("reset_busy",      32'(busy), 32'd0);
    chk("reset_mem_write", 32'(mem_write), 32'd0);
    chk("reset_rdata0",    rdata0, 32'd0);
    chk("reset_mem_addr",  mem_addr, 32'd0);
    chk_en = 1'b1;
    do_reset();

    // 1: single load from word 5.
    wr0 = wr_count;
    do_txn(0, 1'b0, 32'd5, 32'h0, rd, er, lat);
    chk("t1_latency", 32'(lat), 32'd3);
    chk("t1_rdata0",  rd, 32'hDEAD_BEEF);
    chk("t1_err0",    32'(er), 32'd0);
    chk("t1_no_write", 32'(wr_count - wr0), 32'd0);

    // 2: port 1 stores to word 127, port 0 reads it back.
    wr0 = wr_count;
    do_txn(1, 1'b1, 32'd127, 32'h1234_5678, rd, er, lat);
    chk("t2_wr_rdata1", rd, 32'h0);
    do_txn(0, 1'b0, 32'd127, 32'h0, rd, er, lat);
    chk("t2_rdata0",     rd, 32'h1234_5678);
    chk("t2_write_once", 32'(wr_count - wr0), 32'd1);
    chk("t2_write_addr", last_wr_addr, 32'd127);

    // 3: both ports requesting continuously from reset.
    do_reset();
    addr0 = 32'd1; addr1 = 32'd2; we0 = 1'b0; we1 = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      ports[k] = -1; cycs[k] = 0;
      for (int i = 0; i < 8 && !got; i++) begin
        @(negedge clk);
        if (ack0 || ack1) begin
          got = 1'b1;
          ports[k] = ack1 ? 1 : 0;
          cycs[k]  = cyc;
        end
      end
      if (!got) chk("t3_ack_timeout", 32'd0, 32'd1);
    end
    step();
    req0 = 1'b0; req1 = 1'b0;
    for (int k = 0; k < 4; k++) chk("t3_order", 32'(ports[k]), 32'(k % 2));
    for (int k = 1; k < 4; k++) chk("t3_spacing", 32'(cycs[k] - cycs[k-1]), 32'd3);

    // 4: out-of-range store and load.
    wr0 = wr_count;
    do_txn(1, 1'b1, 32'd128, 32'hFFFF_FFFF, rd, er, lat);
    chk("t4_err1",    32'(er), 32'd1);
    chk("t4_rdata1",  rd, 32'h0);
    chk("t4_no_write", 32'(wr_count - wr0), 32'd0);
    chk("t4_word0",   dmem[0], 32'h1000_0000);
    chk("t4_word127", dmem[127], 32'h1234_5678);
    do_txn(0, 1'b0, 32'd200, 32'h0, rd, er, lat);
    chk("t4_err0",   32'(er), 32'd1);
    chk("t4_rdata0", rd, 32'h0);

    // 5: reset lands in the middle of a write's access cycle.
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd10; wdata0 = 32'hA5A5_A5A5;
    step();
    #1;
    chk("t5_write_before_rst", 32'(mem_write), 32'd1);
    rst = 1'b1;
    #1;
    chk("t5_write_dropped", 32'(mem_write), 32'd0);
    chk("t5_busy",          32'(busy), 32'd0);
    chk("t5_ack0",          32'(ack0), 32'd0);
    req0 = 1'b0; we0 = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    step();
    chk("t5_word10", dmem[10], 32'h1000_000A);

    // 6: command changes after grant must not affect the store.
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd20; wdata0 = 32'h1111_2222;
    step();
    addr0 = 32'd21; wdata0 = 32'h3333_4444;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (ack0) got = 1'b1;
    end
    if (!got) chk("t6_ack_timeout", 32'd0, 32'd1);
    step();
    req0 = 1'b0; we0 = 1'b0;
    step();
    chk("t6_word20", dmem[20], 32'h1111_2222);
    chk("t6_word21", dmem[21], 32'h1000_0015);

    // Final memory image must match the reference model.
    chk_en = 1'b0;
    for (int i = 0; i < SIZE_DM; i++) chk("mem_image", dmem[i], refmem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port data memory.
- Port 0 is the CPU load/store path. Port 1 is the debug/loader path, used for program load and memory inspection.
- Grants one access at a time, round-robin. Drives the memory's write/read/address lines and returns registered read data with a one-cycle ack.
- Blocks out-of-range addresses, so the memory is never indexed past its depth.

Parameters:
- SIZE_DM, 128, data memory depth in 32-bit words; legal word addresses are 0..SIZE_DM-1.
- ADDR_W, 32, width of requester and memory address buses.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0  in  1  port 0 request; held high until ack0.
- we0  in  1  port 0 write enable (1 = store, 0 = load); valid while req0 is high.
- addr0  in  ADDR_W  port 0 word address.
- wdata0  in  32  port 0 store data.
- ack0  out  1  one-cycle completion pulse for port 0.
- err0  out  1  high together with ack0 when the address was out of range.
- rdata0  out  32  port 0 load data; valid while ack0 is high.
- req1, we1, addr1, wdata1, ack1, err1, rdata1: same as port 0, for port 1.
- mem_addr  out  ADDR_W  address to data memory.
- mem_wdata  out  32  write data to data memory.
- mem_write  out  1  memory write strobe.
- mem_read  out  1  memory read enable; also drives the memory's memory-to-register select high.
- mem_rdata  in  32  combinational read data from data memory.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE; rr_ptr = 0 (port 0 favoured first).
  - All outputs 0: ack*, err*, rdata*, mem_*, busy.
- State machine: IDLE -> ACCESS -> RESP -> IDLE. Every transaction takes exactly 3 cycles, from grant edge to ack cycle.
- IDLE:
  - If no req is high, stay in IDLE and drive mem_write and mem_read to 0.
  - If exactly one req is high, grant that port.
  - If both are high, grant the port pointed to by rr_ptr.
  - On grant: latch port id, we, addr and wdata into internal registers; compute oor = (addr >= SIZE_DM); go to ACCESS.
- ACCESS (exactly one cycle), driven from the latched values only:
  - mem_addr = latched addr.
  - mem_wdata = latched wdata.
  - mem_write = we & ~oor.
  - mem_read = ~we & ~oor.
  - At the clock edge ending ACCESS: capture mem_rdata into the granted port's rdata register (0 if oor or if the access is a write). Go to RESP.
  - In every other state, mem_write = 0 and mem_read = 0. mem_addr and mem_wdata hold their last value.
- RESP (one cycle):
  - ack of the granted port = 1; err = oor.
  - rdata of the granted port holds the captured value. The other port's rdata is unchanged.
  - rr_ptr = the port that was not granted.
  - Return to IDLE.
- Requester handshake:
  - req must stay high until ack. The requester may deassert req, or present a new request, in the cycle after ack.
  - If req is still high in the IDLE cycle after ack, it is treated as a new request (back-to-back access).
  - req dropping before the grant is permitted; that request is simply not granted.
  - Changes to addr, we or wdata after the grant have no effect on the transaction.
- Fairness: with both ports requesting continuously, grants alternate 0, 1, 0, 1. No port waits more than one transaction (3 cycles) past its first eligible IDLE cycle.
- Out-of-range access:
  - No memory strobe is issued.
  - rdata = 0, ack and err pulse together.
  - rr_ptr advances as for a normal transaction.
- Simultaneous events:
  - Both ports request in the same cycle: rr_ptr decides; the loser's req is still pending at the next IDLE.
  - A new request arriving during ACCESS or RESP waits until IDLE.
- Reset mid-operation:
  - mem_write drops immediately (asynchronous clear).
  - The in-flight transaction is abandoned with no ack.
  - Requesters re-issue after reset.
- Widths: the range compare uses the full ADDR_W bits; addresses are never truncated.

Test Plan:
1. Reset, then req0 = 1, we0 = 0, addr0 = 5, memory word 5 = 0xDEADBEEF. Required: ack0 pulses on the 3rd edge after req0 is seen in IDLE; rdata0 = 0xDEADBEEF; err0 = 0; mem_write never asserted.
2. Port 1 writes 0x12345678 to address 127, then port 0 reads address 127. Required: exactly one mem_write cycle, with mem_addr = 127; rdata0 = 0x12345678; ack1 and ack0 in order.
3. req0 and req1 held high continuously after reset, 4 transactions. Required: acks ordered 0, 1, 0, 1, spaced 3 cycles apart.
4. req1 = 1, we1 = 1, addr1 = 128, wdata1 = 0xFFFFFFFF. Required: ack1 = 1 with err1 = 1; mem_write stays 0 throughout; word 0 and word 127 unchanged. A following read of address 200 returns rdata = 0 with err = 1.
5. rst asserted asynchronously during the ACCESS cycle of a port 0 write. Required: mem_write = 0 within the same cycle; busy = 0; no ack0; the target word keeps its old value if rst precedes the clock edge.
6. req0 pulsed high in IDLE with we0 = 1, then addr0/wdata0 changed in ACCESS. Required: the memory is written with the values latched at grant, not the changed ones.
